mem_dualport_pipe: RTL
======================

MEM_DUALPORT_PIPE -- requirements
Module: mem_dualport_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from request to response (legal 1..3).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port init_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port a_req  input  1  port A (fetch) read request.
REQ-006 SHALL have port a_addr  input  32  port A byte address.
REQ-007 SHALL have port a_rdata  output  32  port A read word.
REQ-008 SHALL have port a_valid  output  1  a_rdata valid, one-cycle pulse per request.
REQ-009 SHALL have port b_req  input  1  port B (data) request.
REQ-010 SHALL have port b_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port b_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-012 SHALL have port b_sext  input  1  load extension: 1 sign, 0 zero.
REQ-013 SHALL have port b_addr  input  32  port B byte address.
REQ-014 SHALL have port b_wdata  input  32  store data, right-justified.
REQ-015 SHALL have port b_rdata  output  32  load result, extended to 32 bits.
REQ-016 SHALL have port b_valid  output  1  port B good-response pulse.
REQ-017 SHALL have port b_fault  output  1  port B misaligned/illegal-response pulse.
REQ-018 SHALL have port busy  output  1  high while initial clear runs; requests ignored.

Function
REQ-019 SHALL use word index = addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap-around).
REQ-020 SHALL be little-endian: byte lane n = bits [8n+7:8n], lane selected by addr[1:0].
REQ-021 SHALL ignore a_addr[1:0]; port A always returns the full word.
REQ-022 SHALL accept a request only in state RUN; a_req/b_req during CLEAR dropped, no response ever.
REQ-023 SHALL return each accepted read/store response exactly RD_LAT cycles after the request cycle; back-to-back requests every cycle fully pipelined on both ports independently.
REQ-024 SHALL commit a store at the rising edge ending its request cycle; only addressed lanes change (byte: 1 lane, half: lanes addr[1]*2..+1, word: all 4).
REQ-025 SHALL flag fault when b_size=11, or half with addr[0]=1, or word with addr[1:0]!=00; faulting store writes nothing.
REQ-026 SHALL respond to every accepted port B request with exactly one of b_valid or b_fault; stores give b_valid with b_rdata=0.
REQ-027 SHALL, for byte/half loads, extend bit 7/bit 15 when b_sext=1, else zero-fill; b_sext ignored for word.
REQ-028 SHALL be write-first: a port A or port B read in the same cycle as a port B store to the same word returns the post-store word.
REQ-029 SHALL return post-store data for any read issued in any cycle after the store cycle.
REQ-030 SHALL drive a_rdata/b_rdata to 0 in any cycle their valid/fault is low.

State machine
REQ-031 SHALL have states CLEAR and RUN; reset enters CLEAR with clear counter 0.
REQ-032 SHALL in CLEAR write 0 to word[counter] and increment each cycle; busy=1.
REQ-033 SHALL go CLEAR->RUN the cycle after counter writes word DEPTH-1; busy falls with RUN (DEPTH cycles busy after reset release).
REQ-034 SHALL stay in RUN until init_n=0; no other transition.

Reset
REQ-035 SHALL, while init_n=0 at a clock edge: a_valid, b_valid, b_fault, a_rdata, b_rdata = 0, busy = 1, all in-flight responses discarded.
REQ-036 SHALL treat reset mid-operation (RUN or CLEAR) identically: pipeline flushed, CLEAR restarts from word 0, no pending store completes after reset edge.

Verification
REQ-037 SHALL cover: init_n low 2 cycles then high, DEPTH=16 -> busy high exactly 16 cycles after release, then any word reads 0x00000000.
REQ-038 SHALL cover: store word 0xDEADBEEF @0x8, load byte @0xB sext=1 -> b_rdata 0xFFFFFFDE; sext=0 -> 0x000000DE; load half @0xA sext=1 -> 0xFFFFDEAD.
REQ-039 SHALL cover: store byte 0x5A @0x9 over 0xDEADBEEF -> port A read @0x8 returns 0xDEAD5AEF; same-cycle A read @0x8 also returns 0xDEAD5AEF.
REQ-040 SHALL cover: load half @0x3, word @0x2, size 11 @0x0 -> three b_fault pulses at RD_LAT, b_valid 0; store word @0x6 leaves memory unchanged.
REQ-041 SHALL cover: RD_LAT=3, b_req every cycle for 8 loads with a_req every cycle -> 8 responses per port, in order, consecutive cycles, first at cycle+3; address DEPTH*4+0x8 aliases 0x8.
REQ-042 SHALL cover: init_n low with 2 loads in flight -> no valid/fault pulses follow, busy reasserts, memory reads 0 after clear.

Source files
------------

// File: rtl/mem_dualport_pipe.sv
// Dual-port 32-bit word memory: port A fetches full words, port B does sized,
// sign/zero-extending loads and lane-masked stores. Both ports have a fixed RD_LAT response pipeline.
module mem_dualport_pipe #(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic [31:0] a_rdata,
    output logic        a_valid,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic        b_sext,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_valid,
    output logic        b_fault,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    // state    | meaning
    // ST_CLEAR | zeroing word[clr_cnt] each cycle, requests dropped
    // ST_RUN   | normal operation, requests accepted
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]   mem_q [DEPTH];

    logic          a_vld_q [RD_LAT];
    logic          a_vld_d [RD_LAT];
    logic [31:0]   a_dat_q [RD_LAT];
    logic [31:0]   a_dat_d [RD_LAT];
    logic          b_vld_q [RD_LAT];
    logic          b_vld_d [RD_LAT];
    logic          b_flt_q [RD_LAT];
    logic          b_flt_d [RD_LAT];
    logic [31:0]   b_dat_q [RD_LAT];
    logic [31:0]   b_dat_d [RD_LAT];

    logic          run;
    logic          a_acc, b_acc, st_en;
    logic [AW-1:0] a_idx, b_idx;
    logic [1:0]    b_off;
    logic          b_mis;
    logic [3:0]    b_lanes;
    logic [31:0]   b_bits, b_wword, b_old, b_merged, b_load, a_word;
    logic [7:0]    b_byte;
    logic [15:0]   b_half;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{a_addr[31:AW+2], a_addr[1:0], b_addr[31:AW+2]};

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN:  clr_cnt_d = '0;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy  = (state_q == ST_CLEAR);
    assign run   = (state_q == ST_RUN) && init_n;
    assign a_acc = a_req && run;
    assign b_acc = b_req && run;
    assign a_idx = a_addr[AW+1:2];
    assign b_idx = b_addr[AW+1:2];
    assign b_off = b_addr[1:0];

    always_comb begin
        b_mis   = 1'b0;
        b_lanes = 4'b0000;
        b_wword = b_wdata;
        case (b_size)
            2'b00: begin
                b_lanes = 4'b0001 << b_off;
                b_wword = {4{b_wdata[7:0]}};
            end
            2'b01: begin
                b_mis   = b_off[0];
                b_lanes = b_off[1] ? 4'b1100 : 4'b0011;
                b_wword = {2{b_wdata[15:0]}};
            end
            2'b10: begin
                b_mis   = (b_off != 2'b00);
                b_lanes = 4'b1111;
            end
            default: b_mis = 1'b1;
        endcase
    end

    assign b_bits   = {{8{b_lanes[3]}}, {8{b_lanes[2]}}, {8{b_lanes[1]}}, {8{b_lanes[0]}}};
    assign b_old    = mem_q[b_idx];
    assign b_merged = (b_old & ~b_bits) | (b_wword & b_bits);
    assign st_en    = b_acc && b_we && !b_mis;

    // Write-first: a same-cycle fetch of the word being stored sees the merged value.
    assign a_word = (st_en && (a_idx == b_idx)) ? b_merged : mem_q[a_idx];

    assign b_byte = b_old[{b_off, 3'b000} +: 8];
    assign b_half = b_old[{b_off[1], 4'b0000} +: 16];

    always_comb begin
        b_load = b_old;
        case (b_size)
            2'b00:   b_load = {{24{b_sext & b_byte[7]}}, b_byte};
            2'b01:   b_load = {{16{b_sext & b_half[15]}}, b_half};
            default: b_load = b_old;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = b_idx;
        wr_data = b_merged;
        if (init_n) begin
            if (state_q == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_idx  = clr_cnt_q;
                wr_data = '0;
            end else if (st_en) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    // Data fields carry zero whenever their pulse is low, so outputs idle at 0.
    always_comb begin
        a_vld_d[0] = a_acc;
        a_dat_d[0] = a_acc ? a_word : '0;
        b_vld_d[0] = b_acc && !b_mis;
        b_flt_d[0] = b_acc && b_mis;
        b_dat_d[0] = (b_acc && !b_mis && !b_we) ? b_load : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            a_vld_d[i] = a_vld_q[i-1];
            a_dat_d[i] = a_dat_q[i-1];
            b_vld_d[i] = b_vld_q[i-1];
            b_flt_d[i] = b_flt_q[i-1];
            b_dat_d[i] = b_dat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RD_LAT; i++) begin
            if (!init_n) begin
                a_vld_q[i] <= 1'b0;
                a_dat_q[i] <= '0;
                b_vld_q[i] <= 1'b0;
                b_flt_q[i] <= 1'b0;
                b_dat_q[i] <= '0;
            end else begin
                a_vld_q[i] <= a_vld_d[i];
                a_dat_q[i] <= a_dat_d[i];
                b_vld_q[i] <= b_vld_d[i];
                b_flt_q[i] <= b_flt_d[i];
                b_dat_q[i] <= b_dat_d[i];
            end
        end
    end

    assign a_valid = a_vld_q[RD_LAT-1];
    assign a_rdata = a_dat_q[RD_LAT-1];
    assign b_valid = b_vld_q[RD_LAT-1];
    assign b_fault = b_flt_q[RD_LAT-1];
    assign b_rdata = b_dat_q[RD_LAT-1];

endmodule
